// File: rtl/argmax_scheduler.sv
// Round-robin front end sharing one argmax engine among NUM_REQ lanes:
// grant a lane, latch its vector, launch the engine, wait (bounded) for done, return the index.
module argmax_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_INPUT  = 10,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 32
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [NUM_REQ-1:0]                        i_req,
  input  logic [NUM_REQ*NUM_INPUT*DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]                        o_req_ack,
  output logic [NUM_REQ-1:0]                        o_resp_valid,
  output logic [31:0]                               o_resp_data,
  output logic                                      o_resp_timeout,
  output logic [NUM_INPUT*DATA_WIDTH-1:0]           o_mf_data,
  output logic                                      o_mf_valid,
  input  logic [31:0]                               i_mf_data,
  input  logic                                      i_mf_valid,
  output logic                                      o_busy,
  output logic [$clog2(NUM_REQ)-1:0]                o_grant_id
);

  localparam int VEC_W = NUM_INPUT * DATA_WIDTH;
  localparam int GW    = $clog2(NUM_REQ);
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW:0]   REQ_N    = (GW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t              state_reg;
  logic [GW-1:0]       last_grant_reg;
  logic [CW-1:0]       cnt_reg;

  logic [VEC_W-1:0]    lane_vec [NUM_REQ];
  logic [GW-1:0]       rot_idx  [NUM_REQ];
  logic                pick_valid;
  logic [GW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [NUM_REQ-1:0]  grant_onehot;

  // rot_idx[k] is the lane k+1 positions past the last grant, wrapping at NUM_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      logic [GW:0] rot_sum;
      assign lane_vec[gi] = i_req_data[gi*VEC_W +: VEC_W];
      assign rot_sum      = {1'b0, last_grant_reg} + (GW + 1)'(gi + 1);
      assign rot_idx[gi]  = (rot_sum >= REQ_N) ? GW'(rot_sum - REQ_N) : GW'(rot_sum);
    end
  endgenerate

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[rot_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx[k];
      end
    end
  end

  assign pick_onehot  = NUM_REQ'(1) << pick_idx;
  assign grant_onehot = NUM_REQ'(1) << o_grant_id;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= GW'(NUM_REQ - 1);
      cnt_reg        <= '0;
      o_req_ack      <= '0;
      o_resp_valid   <= '0;
      o_resp_data    <= '0;
      o_resp_timeout <= 1'b0;
      o_mf_data      <= '0;
      o_mf_valid     <= 1'b0;
      o_busy         <= 1'b0;
      o_grant_id     <= '0;
    end else begin
      o_req_ack    <= '0;
      o_resp_valid <= '0;
      o_mf_valid   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            o_mf_data  <= lane_vec[pick_idx];
            o_grant_id <= pick_idx;
            o_req_ack  <= pick_onehot;
            o_busy     <= 1'b1;
            state_reg  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          o_mf_valid <= 1'b1;
          cnt_reg    <= '0;
          state_reg  <= S_WAIT;
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          // A done pulse on the last allowed cycle still counts as success.
          if (i_mf_valid) begin
            o_resp_data    <= i_mf_data;
            o_resp_timeout <= 1'b0;
            o_resp_valid   <= grant_onehot;
            state_reg      <= S_RESP;
          end else if (cnt_reg == CNT_LAST) begin
            o_resp_data    <= 32'hFFFF_FFFF;
            o_resp_timeout <= 1'b1;
            o_resp_valid   <= grant_onehot;
            state_reg      <= S_RESP;
          end
        end
        S_RESP: begin
          last_grant_reg <= o_grant_id;
          o_busy         <= 1'b0;
          state_reg      <= S_IDLE;
        end
        default: begin
          o_busy    <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_scheduler.sv
// Randomized bench for argmax_scheduler: a lane/priority model plus a bench-side
// engine that answers after a chosen latency (or never).
module tb_argmax_scheduler;
  localparam int NR = 4, NI = 10, DW = 16, TO = 32;
  localparam int VW = NI * DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*VW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ack, resp_valid;
  logic [31:0]       resp_data;
  logic              resp_timeout;
  logic [VW-1:0]     mf_data;
  logic              mf_valid;
  logic [31:0]       mf_res = '0;
  logic              mf_done = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;

  int total = 0, bad = 0;
  int last_grant = NR - 1;
  logic [VW-1:0] vec [NR];

  always #5 clk = ~clk;

  argmax_scheduler #(.NUM_REQ(NR), .NUM_INPUT(NI), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
    .o_req_ack(req_ack), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
    .o_resp_timeout(resp_timeout), .o_mf_data(mf_data), .o_mf_valid(mf_valid),
    .i_mf_data(mf_res), .i_mf_valid(mf_done), .o_busy(busy), .o_grant_id(grant_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int argmax(input logic [VW-1:0] v);
    int best = 0;
    for (int k = 1; k < NI; k++)
      if (v[k*DW +: DW] > v[best*DW +: DW]) best = k;
    return best;
  endfunction

  function automatic int next_grant(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic load_vectors();
    for (int l = 0; l < NR; l++) begin
      for (int e = 0; e < NI; e++) vec[l][e*DW +: DW] = 16'($urandom);
      req_data[l*VW +: VW] = vec[l];
    end
  endtask

  // Drives one full transaction and reports what was observed; lat=0 means the engine never answers.
  task automatic run_txn(input int lat, input logic [31:0] res, input bit drop, input bit stray,
                         output logic [NR-1:0] ack, output int gid, output logic [VW-1:0] mfd,
                         output int ack_cyc, output logic mfv, output logic [NR-1:0] rv,
                         output logic [31:0] rd, output logic rto, output int resp_cyc);
    ack = '0; gid = -1; mfd = '0; ack_cyc = -1; mfv = 1'b0;
    rv = '0; rd = '0; rto = 1'b0; resp_cyc = -1;
    for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
      step();
      if (req_ack != '0) begin
        ack_cyc = c; ack = req_ack; gid = int'(grant_id); mfd = mf_data;
      end
    end
    if (ack_cyc < 0) return;
    if (drop) req = req & ~ack;
    if (stray) begin
      mf_done = 1'b1; mf_res = 32'hDEAD;
    end
    step();
    mf_done = 1'b0;
    mfv = mf_valid;
    for (int c = 1; c <= TO + 8 && resp_cyc < 0; c++) begin
      if (lat >= 1 && c == lat) begin
        mf_done = 1'b1; mf_res = res;
      end
      step();
      mf_done = 1'b0;
      if (resp_valid != '0) begin
        resp_cyc = c; rv = resp_valid; rd = resp_data; rto = resp_timeout;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++;
    if ({req_ack, resp_valid, resp_timeout, mf_valid, busy, grant_id} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {req_ack, resp_valid, resp_timeout, mf_valid, busy, grant_id});
    end
    total++;
    if (resp_data !== 32'd0) begin bad++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    total++;
    if (mf_data !== '0) begin bad++; $display("FAIL reset_mf_data: got %h want 0", mf_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [NR-1:0] ack, rv; int gid, ac, rc; logic [VW-1:0] mfd; logic mfv, rto; logic [31:0] rd;
    load_vectors();
    for (int e = 0; e < NI; e++) vec[2][e*DW +: DW] = 16'($urandom_range(0, 1000));
    vec[2][7*DW +: DW] = 16'd5000;
    req_data[2*VW +: VW] = vec[2];
    req = 4'b0100;
    run_txn(11, 32'(argmax(vec[2])), 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = 2;
    total++; if (ac !== 1) begin bad++; $display("FAIL single_ack_latency: got %0d want 1", ac); end
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b want 0100", ack); end
    total++; if (mfd !== vec[2]) begin bad++; $display("FAIL single_mf_data: got %h want %h", mfd, vec[2]); end
    total++; if (mfv !== 1'b1) begin bad++; $display("FAIL single_mf_valid: got %b want 1", mfv); end
    total++; if (rc !== 11) begin bad++; $display("FAIL single_resp_latency: got %0d want 11", rc); end
    total++; if (rv !== 4'b0100) begin bad++; $display("FAIL single_resp_valid: got %b want 0100", rv); end
    total++; if (rd !== 32'd7 || rto !== 1'b0) begin bad++; $display("FAIL single_resp_data: got %0d/%b want 7/0", rd, rto); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_stray_valid();
    logic [NR-1:0] ack, rv; int gid, ac, rc, exp; logic [VW-1:0] mfd; logic mfv, rto; logic [31:0] rd;
    logic seen = 1'b0;
    req = '0;
    mf_done = 1'b1; mf_res = 32'd9;
    for (int c = 0; c < 3; c++) begin
      step();
      seen = seen | (|resp_valid) | busy;
    end
    mf_done = 1'b0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL stray_idle: got %b want 0", seen); end
    load_vectors();
    req = 4'b0001;
    exp = next_grant(req, last_grant);
    run_txn(5, 32'(argmax(vec[exp])), 1'b1, 1'b1, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = exp;
    total++; if (gid !== exp) begin bad++; $display("FAIL stray_grant: got %0d want %0d", gid, exp); end
    total++; if (rc !== 5) begin bad++; $display("FAIL stray_resp_latency: got %0d want 5", rc); end
    total++; if (rd !== 32'(argmax(vec[exp]))) begin bad++; $display("FAIL stray_resp_data: got %h want %0d", rd, argmax(vec[exp])); end
  endtask

  task automatic test_timeout();
    logic [NR-1:0] ack, rv; int gid, ac, rc, exp; logic [VW-1:0] mfd; logic mfv, rto; logic [31:0] rd;
    load_vectors();
    req = 4'b1010;
    exp = next_grant(req, last_grant);
    run_txn(0, 32'd0, 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = exp;
    total++; if (rc !== TO) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", rc, TO); end
    total++; if (rv !== NR'(1 << exp)) begin bad++; $display("FAIL timeout_resp_valid: got %b want lane %0d", rv, exp); end
    total++; if (rd !== 32'hFFFF_FFFF || rto !== 1'b1) begin bad++; $display("FAIL timeout_data: got %h/%b want ffffffff/1", rd, rto); end
    req = 4'b1000;
    exp = next_grant(req, last_grant);
    run_txn(4, 32'(argmax(vec[exp])), 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = exp;
    total++; if (rd !== 32'(argmax(vec[exp])) || rto !== 1'b0 || rc !== 4) begin
      bad++; $display("FAIL timeout_recover: got %h/%b/%0d want %0d/0/4", rd, rto, rc, argmax(vec[exp]));
    end
  endtask

  task automatic test_coincide();
    logic [NR-1:0] ack, rv; int gid, ac, rc, exp; logic [VW-1:0] mfd; logic mfv, rto; logic [31:0] rd;
    load_vectors();
    req = 4'b0001;
    exp = next_grant(req, last_grant);
    run_txn(TO, 32'd3, 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = exp;
    total++; if (rd !== 32'd3 || rto !== 1'b0) begin bad++; $display("FAIL coincide_data: got %h/%b want 3/0", rd, rto); end
    total++; if (rc !== TO) begin bad++; $display("FAIL coincide_latency: got %0d want %0d", rc, TO); end
  endtask

  task automatic test_reset_mid_wait();
    logic [NR-1:0] ack, rv; int gid, ac, rc, exp; logic [VW-1:0] mfd; logic mfv, rto; logic [31:0] rd;
    logic seen = 1'b0;
    load_vectors();
    req = 4'b0100;
    run_txn(3, 32'd6, 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = 2;
    req = 4'b0010;
    step();
    total++; if (req_ack !== 4'b0010) begin bad++; $display("FAIL rstmid_ack: got %b want 0010", req_ack); end
    req = '0;
    for (int c = 0; c < 6; c++) step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ack, resp_valid, resp_timeout, mf_valid, busy, grant_id} !== '0 || resp_data !== 32'd0 || mf_data !== '0) begin
      bad++; $display("FAIL rstmid_outputs: got ctrl=%b data=%h busy=%b want all 0", {req_ack, resp_valid, grant_id}, resp_data, busy);
    end
    step();
    rst_n = 1'b1;
    last_grant = NR - 1;
    mf_done = 1'b1; mf_res = 32'd5;
    step();
    mf_done = 1'b0;
    seen = (|resp_valid) | busy;
    for (int c = 0; c < 4; c++) begin
      step();
      seen = seen | (|resp_valid) | busy;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_resp: got %b want 0", seen); end
    req = 4'b1001;
    exp = next_grant(req, last_grant);
    run_txn(2, 32'(argmax(vec[exp])), 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = exp;
    total++; if (gid !== 0) begin bad++; $display("FAIL rstmid_first_grant: got %0d want 0", gid); end
    exp = next_grant(req, last_grant);
    run_txn(2, 32'(argmax(vec[exp])), 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
    last_grant = exp;
    total++; if (gid !== 3 || rd !== 32'(argmax(vec[3]))) begin bad++; $display("FAIL rstmid_lane3: got %0d/%h want 3/%0d", gid, rd, argmax(vec[3])); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] ack, rv; int gid, ac, rc, exp; logic [VW-1:0] mfd; logic mfv, rto; logic [31:0] rd;
    load_vectors();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp = next_grant(req, last_grant);
      run_txn(2 + t, 32'(argmax(vec[exp])), 1'b0, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
      last_grant = exp;
      total++;
      if (gid !== exp || ack !== NR'(1 << exp) || mfd !== vec[exp] || ac !== 1 || rd !== 32'(argmax(vec[exp]))) begin
        bad++; $display("FAIL rr_txn%0d: got lane=%0d ack=%b wait=%0d rd=%h want lane=%0d wait=1 rd=%0d", t, gid, ack, ac, rd, exp, argmax(vec[exp]));
      end
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] ack, rv; int gid, ac, rc, exp, lat; logic [VW-1:0] mfd; logic mfv, rto; logic [31:0] rd;
    logic [31:0] want_rd; int want_rc;
    for (int t = 0; t < 12; t++) begin
      load_vectors();
      req = NR'($urandom_range(1, 15));
      lat = $urandom_range(1, TO + 2);
      exp = next_grant(req, last_grant);
      run_txn(lat, 32'(argmax(vec[exp])), 1'b1, 1'b0, ack, gid, mfd, ac, mfv, rv, rd, rto, rc);
      last_grant = exp;
      want_rd = (lat <= TO) ? 32'(argmax(vec[exp])) : 32'hFFFF_FFFF;
      want_rc = (lat <= TO) ? lat : TO;
      total++;
      if (gid !== exp || mfd !== vec[exp] || rv !== NR'(1 << exp) || rd !== want_rd || rto !== (lat > TO) || rc !== want_rc) begin
        bad++; $display("FAIL rand_txn%0d: got lane=%0d rv=%b rd=%h to=%b lat=%0d want lane=%0d rd=%h lat=%0d", t, gid, rv, rd, rto, rc, exp, want_rd, want_rc);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stray_valid();
    test_timeout();
    test_coincide();
    test_reset_mid_wait();
    test_round_robin();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/argmax_scheduler.md
Name: argmax_scheduler

Overview:
- Shares one argmax (max-finder) engine among NUM_REQ inference lanes.
- Each lane presents a full final-layer output vector. The scheduler arbitrates round-robin, latches the winner's vector, launches the engine with a one-cycle valid, waits for its done pulse (with timeout), and returns the class index to the granted lane.
- Sits between the last neuron layer of each lane and the shared engine.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- NUM_INPUT, 10, vector elements per request (final-layer neuron count).
- DATA_WIDTH, 16, bits per element.
- TIMEOUT, 32, max cycles spent in WAIT before aborting; must be > NUM_INPUT+1.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-lane request level; lane holds it until its ack.
- i_req_data  in  NUM_REQ*NUM_INPUT*DATA_WIDTH  lane k vector at [k*NUM_INPUT*DATA_WIDTH +: NUM_INPUT*DATA_WIDTH].
- o_req_ack  out  NUM_REQ  one-cycle pulse, one-hot: vector of that lane latched.
- o_resp_valid  out  NUM_REQ  one-cycle pulse, one-hot: result for that lane on o_resp_data.
- o_resp_data  out  32  argmax index returned by engine; 32'hFFFF_FFFF on timeout.
- o_resp_timeout  out  1  qualifies o_resp_valid: 1 = engine never answered.
- o_mf_data  out  NUM_INPUT*DATA_WIDTH  latched vector to engine.
- o_mf_valid  out  1  one-cycle engine start.
- i_mf_data  in  32  engine result index.
- i_mf_valid  in  1  engine done pulse.
- o_busy  out  1  high in any state but IDLE.
- o_grant_id  out  $clog2(NUM_REQ)  lane currently or last served.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - o_req_ack, o_resp_valid, o_mf_valid, o_resp_timeout, o_busy = 0.
  - o_resp_data = 0, o_mf_data = 0, o_grant_id = 0.
  - Last-grant pointer = NUM_REQ-1, so lane 0 has first priority.
  - Timeout counter = 0.
- All outputs are registered.
- States: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - If i_req != 0: pick the first set lane searching upward from last_grant+1, with wrap.
  - Latch that lane's slice into o_mf_data, set o_grant_id, pulse o_req_ack[g] for one cycle, go to LAUNCH.
  - If no request, stay in IDLE; no outputs change.
- LAUNCH:
  - o_mf_valid=1 for exactly this one cycle; clear counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - If i_mf_valid: o_resp_data<=i_mf_data, o_resp_timeout<=0, go to RESP.
  - Else if counter==TIMEOUT-1: o_resp_data<=32'hFFFF_FFFF, o_resp_timeout<=1, go to RESP.
  - If i_mf_valid arrives in the same cycle as the timeout condition, success wins.
- RESP:
  - o_resp_valid[g]=1 for this one cycle; last_grant<=g; go to IDLE.
  - o_resp_data and o_resp_timeout hold their value until the next response.
- o_mf_data is stable from ack until the next grant.
- i_mf_valid is ignored outside WAIT; a stray pulse never produces a response.
- i_req changes while busy are ignored; arbitration happens only in IDLE.
- A lane that keeps i_req high after its ack is treated as a new request. Round-robin order still holds, so no lane is starved.
- Latency:
  - Request seen in IDLE -> ack one cycle later.
  - o_mf_valid two cycles after the request sample.
  - o_resp_valid one cycle after the i_mf_valid sample.
  - Minimum back-to-back spacing between grants is 4 cycles plus engine latency.
- Reset mid-operation: immediate return to the IDLE reset values. Any engine result arriving after reset is ignored, and no response is issued for the aborted request.
- Widths: the counter is $clog2(TIMEOUT+1) bits. i_mf_data is passed through unmodified; no range check against NUM_INPUT.

Test Plan:
- Single request, lane 2, vector with max at index 7; engine model returns 7 eleven cycles after o_mf_valid.
  - Required: o_req_ack=4'b0100 one cycle after request; o_mf_valid pulse; o_resp_valid=4'b0100, o_resp_data=7, o_resp_timeout=0.
- All 4 lanes hold i_req continuously.
  - Required: grant order 0,1,2,3,0; each o_req_ack one-hot; each o_mf_data matches the granted lane's slice.
- Engine never answers, TIMEOUT=32.
  - Required: o_resp_valid for the granted lane exactly 32 WAIT cycles after entering WAIT; o_resp_data=32'hFFFF_FFFF, o_resp_timeout=1; next request is then served normally.
- i_mf_valid pulsed while in IDLE and during LAUNCH.
  - Required: no o_resp_valid, state unchanged/sequence unaffected; the later real done still returns the correct index.
- i_rst_n driven low for 1 cycle mid-WAIT (lane 1), then engine done arrives.
  - Required: all outputs at reset values immediately; no response to lane 1; first post-reset request from lane 3 granted with priority order starting at lane 0.
- i_mf_valid coincides with the final timeout cycle, i_mf_data=3.
  - Required: o_resp_data=3, o_resp_timeout=0.
